phase_ctrl: RTL and testbench

PHASE_CTRL -- requirements
Module: phase_ctrl

---
 rtl/phase_pkg.sv | 34 +++
 rtl/phase_ctrl_if.sv | 24 ++
 rtl/mem_wdog.sv | 28 ++
 rtl/phase_ctrl.sv | 107 ++++++++++
 tb/tb_phase_ctrl.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/phase_pkg.sv
// Shared phase-controller types: state encoding and one-hot phase enables.
// Imported by the controller, its watchdog and the bench.
package phase_pkg;

  localparam int PH_W = 5;

  localparam logic [PH_W-1:0] PH_F = 5'b00001;
  localparam logic [PH_W-1:0] PH_R = 5'b00010;
  localparam logic [PH_W-1:0] PH_X = 5'b00100;
  localparam logic [PH_W-1:0] PH_M = 5'b01000;
  localparam logic [PH_W-1:0] PH_W_ = 5'b10000;

  typedef enum logic [2:0] {
    S_F,
    S_R,
    S_X,
    S_M,
    S_W,
    S_HALT,
    S_DBG
  } state_t;

  function automatic logic [PH_W-1:0] phase_of(state_t s);
    case (s)
      S_F:     return PH_F;
      S_R:     return PH_R;
      S_X:     return PH_X;
      S_M:     return PH_M;
      S_W:     return PH_W_;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/phase_ctrl_if.sv
// Memory/decode handshake between the phase controller and the datapath.
// master = controller side, slave = datapath/memory side.
interface phase_ctrl_if;

  logic is_hlt;
  logic mem_op;
  logic mem_ack;
  logic mem_req;

  modport master (
    input  is_hlt,
    input  mem_op,
    input  mem_ack,
    output mem_req
  );

  modport slave (
    output is_hlt,
    output mem_op,
    output mem_ack,
    input  mem_req
  );

endinterface

// File: rtl/mem_wdog.sv
// Memory wait watchdog: expire fires on the TIMEOUT-th consecutive
// waiting cycle, so the next edge can take the controller to HALT.
module mem_wdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic waiting,
  input  logic clear,
  output logic expire
);

  localparam int W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt;

  assign expire = waiting && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (waiting && !expire) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/phase_ctrl.sv
// Five-phase instruction sequencer with HLT, memory timeout and
// debugger stop/single-step, plus active-cycle and retire counters.
module phase_ctrl
  import phase_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  phase_ctrl_if.master     bus,
  input  logic             dbg_halt_req,
  input  logic             dbg_step,
  output logic [PH_W-1:0]  phase,
  output logic             halted,
  output logic             mem_err,
  output logic             dbg_halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  state_t     state, state_nx;
  logic       step_q, step_nx;
  logic       op_q;
  logic       err_q;
  logic       expire;
  logic       waiting;
  logic       clear;
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] instr_q;

  assign bus.mem_req = (state == S_F) || ((state == S_M) && op_q);
  assign waiting     = bus.mem_req && !bus.mem_ack;
  assign clear       = bus.mem_ack || (state_nx != state);

  mem_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .waiting (waiting),
    .clear   (clear),
    .expire  (expire)
  );

  always_comb begin
    state_nx = state;
    step_nx  = step_q;
    unique case (state)
      S_F: begin
        if (expire)           state_nx = S_HALT;
        else if (bus.mem_ack) state_nx = S_R;
      end
      S_R: state_nx = S_X;
      S_X: state_nx = bus.is_hlt ? S_HALT : S_M;
      S_M: begin
        if (expire)                    state_nx = S_HALT;
        else if (!op_q || bus.mem_ack) state_nx = S_W;
      end
      S_W: begin
        // a pending step returns here after its one instruction
        if (dbg_halt_req || step_q) begin
          state_nx = S_DBG;
          step_nx  = 1'b0;
        end else begin
          state_nx = S_F;
        end
      end
      S_DBG: begin
        if (!dbg_halt_req) begin
          state_nx = S_F;
        end else if (dbg_step) begin
          state_nx = S_F;
          step_nx  = 1'b1;
        end
      end
      S_HALT: state_nx = S_HALT;
      default: state_nx = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_F;
      step_q  <= 1'b0;
      op_q    <= 1'b0;
      err_q   <= 1'b0;
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      state  <= state_nx;
      step_q <= step_nx;
      if (state == S_X) op_q <= bus.mem_op;
      if (expire) err_q <= 1'b1;
      if (phase != '0) cycle_q <= cycle_q + CNT_W'(1);
      if (state == S_W) instr_q <= instr_q + CNT_W'(1);
    end
  end

  assign phase      = phase_of(state);
  assign halted     = (state == S_HALT);
  assign dbg_halted = (state == S_DBG);
  assign mem_err    = err_q;
  assign cycle_cnt  = cycle_q;
  assign instr_cnt  = instr_q;

endmodule

// File: tb/tb_phase_ctrl.sv
// Directed bench for phase_ctrl: vector table for free-run sequencing,
// hand sequences for wait, timeout, HLT, debug step, reset and wrap.
module tb_phase_ctrl;
  import phase_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dbg_halt_req = 1'b0;
  logic dbg_step = 1'b0;
  logic [4:0]  phase;
  logic        halted, mem_err, dbg_halted;
  logic [31:0] cycle_cnt, instr_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  phase_ctrl_if bus ();

  phase_ctrl #(.CNT_W(32), .TIMEOUT(15)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .dbg_halt_req (dbg_halt_req),
    .dbg_step     (dbg_step),
    .phase        (phase),
    .halted       (halted),
    .mem_err      (mem_err),
    .dbg_halted   (dbg_halted),
    .cycle_cnt    (cycle_cnt),
    .instr_cnt    (instr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ack;
    logic       op;
    logic       hlt;
    logic [4:0] ph;
    logic       req;
    int         instr;
  } vec_t;

  vec_t tbl[21];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 5'h02, 1'b0, 0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 5'h04, 1'b0, 0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 5'h08, 1'b0, 0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 5'h10, 1'b0, 0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 5'h01, 1'b1, 1};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 5'h02, 1'b0, 1};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 5'h04, 1'b0, 1};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 5'h08, 1'b0, 1};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 5'h10, 1'b0, 1};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 5'h01, 1'b1, 2};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 5'h02, 1'b0, 2};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 5'h04, 1'b0, 2};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 5'h08, 1'b0, 2};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 5'h10, 1'b0, 2};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 5'h01, 1'b1, 3};
    tbl[15] = '{1'b1, 1'b1, 1'b0, 5'h02, 1'b0, 3};
    tbl[16] = '{1'b1, 1'b1, 1'b0, 5'h04, 1'b0, 3};
    tbl[17] = '{1'b1, 1'b1, 1'b0, 5'h08, 1'b1, 3};
    tbl[18] = '{1'b0, 1'b1, 1'b0, 5'h08, 1'b1, 3};
    tbl[19] = '{1'b1, 1'b0, 1'b0, 5'h10, 1'b0, 3};
    tbl[20] = '{1'b1, 1'b0, 1'b0, 5'h01, 1'b1, 4};

    bus.is_hlt  = 1'b0;
    bus.mem_op  = 1'b0;
    bus.mem_ack = 1'b0;

    do_reset();
    chk("rst_phase", 64'(phase), 64'h01);
    chk("rst_req", 64'(bus.mem_req), 64'd1);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_err", 64'(mem_err), 64'd0);
    chk("rst_dbg", 64'(dbg_halted), 64'd0);
    chk("rst_cyc", 64'(cycle_cnt), 64'd0);
    chk("rst_ins", 64'(instr_cnt), 64'd0);

    // free-run sequencing, ack-ignored and mem_op wait in M
    for (int i = 0; i < 21; i++) begin
      bus.mem_ack = tbl[i].ack;
      bus.mem_op  = tbl[i].op;
      bus.is_hlt  = tbl[i].hlt;
      tick();
      chk($sformatf("vec%0d_phase", i), 64'(phase), 64'(tbl[i].ph));
      chk($sformatf("vec%0d_req", i), 64'(bus.mem_req), 64'(tbl[i].req));
      chk($sformatf("vec%0d_ins", i), 64'(instr_cnt), 64'(tbl[i].instr));
      chk($sformatf("vec%0d_cyc", i), 64'(cycle_cnt), 64'(i + 1));
    end

    // fetch ack delayed 3 cycles
    bus.mem_op  = 1'b0;
    bus.mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wait_phase", 64'(phase), 64'h01);
      chk("wait_cyc", 64'(cycle_cnt), 64'(22 + i));
    end
    bus.mem_ack = 1'b1;
    tick();
    chk("wait_done", 64'(phase), 64'h02);
    tick(4);
    chk("wait_back_f", 64'(phase), 64'h01);
    chk("wait_cyc_end", 64'(cycle_cnt), 64'd29);
    chk("wait_ins", 64'(instr_cnt), 64'd5);
    chk("wait_noerr", 64'(mem_err), 64'd0);

    // HLT in X
    tick(2);
    bus.is_hlt = 1'b1;
    tick();
    bus.is_hlt = 1'b0;
    chk("hlt_phase", 64'(phase), 64'h00);
    chk("hlt_halted", 64'(halted), 64'd1);
    chk("hlt_ins", 64'(instr_cnt), 64'd5);
    chk("hlt_cyc", 64'(cycle_cnt), 64'd32);
    tick(3);
    chk("hlt_stay", 64'(phase), 64'h00);
    chk("hlt_frozen", 64'(cycle_cnt), 64'd32);

    // debugger stop, single step, release with step ignored
    do_reset();
    bus.mem_ack = 1'b1;
    tick();
    chk("dbg_in_r", 64'(phase), 64'h02);
    dbg_halt_req = 1'b1;
    tick(3);
    chk("dbg_in_w", 64'(phase), 64'h10);
    tick();
    chk("dbg_stop", 64'(dbg_halted), 64'd1);
    chk("dbg_phase", 64'(phase), 64'h00);
    chk("dbg_ins1", 64'(instr_cnt), 64'd1);
    tick(2);
    chk("dbg_hold", 64'(dbg_halted), 64'd1);
    chk("dbg_cyc", 64'(cycle_cnt), 64'd5);
    dbg_step = 1'b1;
    tick();
    dbg_step = 1'b0;
    chk("step_f", 64'(phase), 64'h01);
    tick(4);
    chk("step_w", 64'(phase), 64'h10);
    tick();
    chk("step_back", 64'(dbg_halted), 64'd1);
    chk("step_ins", 64'(instr_cnt), 64'd2);
    chk("step_cyc", 64'(cycle_cnt), 64'd10);
    dbg_halt_req = 1'b0;
    dbg_step = 1'b1;
    tick();
    dbg_step = 1'b0;
    chk("resume_f", 64'(phase), 64'h01);
    chk("resume_dbg", 64'(dbg_halted), 64'd0);
    tick(5);
    chk("freerun_f", 64'(phase), 64'h01);
    chk("freerun_ins", 64'(instr_cnt), 64'd3);

    // memory timeout in F
    bus.mem_ack = 1'b0;
    do_reset();
    tick(14);
    chk("to_pre_phase", 64'(phase), 64'h01);
    chk("to_pre_err", 64'(mem_err), 64'd0);
    tick();
    chk("to_err", 64'(mem_err), 64'd1);
    chk("to_halted", 64'(halted), 64'd1);
    chk("to_phase", 64'(phase), 64'h00);
    chk("to_cyc", 64'(cycle_cnt), 64'd15);
    bus.mem_ack = 1'b1;
    tick(3);
    chk("to_stay", 64'(phase), 64'h00);
    chk("to_sticky", 64'(mem_err), 64'd1);

    // reset mid memory wait; ack in the first F is accepted
    do_reset();
    chk("to_clr_err", 64'(mem_err), 64'd0);
    bus.mem_op = 1'b1;
    tick(3);
    bus.mem_ack = 1'b0;
    tick();
    chk("mid_m_wait", 64'(phase), 64'h08);
    bus.mem_ack = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_f", 64'(phase), 64'h01);
    tick();
    chk("mid_rst_ack", 64'(phase), 64'h02);

    // counter wrap from all-ones
    bus.mem_op = 1'b0;
    do_reset();
    tick(4);
    chk("wrap_in_w", 64'(phase), 64'h10);
    force dut.cycle_q = '1;
    force dut.instr_q = '1;
    #1;
    release dut.cycle_q;
    release dut.instr_q;
    #1;
    chk("wrap_pre_cyc", 64'(cycle_cnt), 64'hFFFF_FFFF);
    tick();
    chk("wrap_cyc", 64'(cycle_cnt), 64'd0);
    chk("wrap_ins", 64'(instr_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
